// File: rtl/nfc_subcarrier_detect.sv
// nfc_subcarrier_detect: NFC receive-path subcarrier energy detector.
// Each ADC sample goes through three steps:
//   1. DC removal
//   2. rectification and a WIN_LEN-sample sliding-window sum (energy)
//   3. a hysteresis comparator that drives carrier_on and carrier_chg
// Latency from the adc_data_en cycle: energy_en at +3, carrier_on/carrier_chg at +4.
// Optional feature: define SUBCARRIER_DC_REMOVE_EN to enable the IIR DC tracker.
// Without it, the fixed midscale (2048) is subtracted instead.
module nfc_subcarrier_detect #(
  parameter int unsigned DC_SHIFT = 6,
  parameter int unsigned WIN_LEN  = 3,
  parameter logic [15:0] TH_HI    = 16'd1200,
  parameter logic [15:0] TH_LO    = 16'd600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_data_en,
  input  logic [11:0] adc_data,
  output logic        energy_en,
  output logic [15:0] energy,
  output logic        carrier_on,
  output logic        carrier_chg
);

  localparam int unsigned ACC_W = 12 + DC_SHIFT;
  // The tracker starts at midscale; 2048 << DC_SHIFT is just the accumulator MSB.
  localparam logic [ACC_W-1:0] ACC_RST = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [11:0]      DC_MID  = ACC_RST[ACC_W-1 -: 12];

  logic signed [12:0] ac_d, ac_q;
  logic               v1_q, v2_q;
  logic [11:0]        mag_d, mag_q;
  logic [11:0]        win_q [WIN_LEN];
  logic [15:0]        energy_d, energy_q;
  logic               energy_en_q;
  logic               carrier_on_q, carrier_chg_q;

`ifdef SUBCARRIER_DC_REMOVE_EN
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [11:0]      dc;

  assign dc = acc_q[ACC_W-1 -: 12];

  // AC sample and next accumulator value, both using dc from before the update
  always_comb begin
    ac_d  = $signed({1'b0, adc_data}) - $signed({1'b0, dc});
    // Modular arithmetic is exact here: the true result always lies in range.
    acc_d = acc_q + ACC_W'(adc_data) - ACC_W'(dc);
  end

  // DC tracker accumulator, advances only on sample strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= ACC_RST;
    end else if (adc_data_en) begin
      acc_q <= acc_d;
    end
  end
`else
  // AC sample against the fixed midscale
  always_comb begin
    ac_d = $signed({1'b0, adc_data}) - $signed({1'b0, DC_MID});
  end
`endif

  // Stage 1: register the AC sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      ac_q <= '0;
    end else begin
      v1_q <= adc_data_en;
      if (adc_data_en) ac_q <= ac_d;
    end
  end

  // Rectify; |ac| <= 4095 always fits in 12 bits
  always_comb begin
    mag_d = ac_q[12] ? 12'(-ac_q) : ac_q[11:0];
  end

  // Stage 2: register the magnitude
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q  <= 1'b0;
      mag_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) mag_q <= mag_d;
    end
  end

  // Running window sum; the window starts zeroed, so the first outputs are partial sums
  always_comb begin
    energy_d = energy_q + 16'(mag_q) - 16'(win_q[WIN_LEN-1]);
  end

  // Stage 3: shift the window and update the energy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      energy_en_q <= 1'b0;
      energy_q    <= '0;
      for (int unsigned i = 0; i < WIN_LEN; i++) win_q[i] <= '0;
    end else begin
      energy_en_q <= v2_q;
      if (v2_q) begin
        energy_q <= energy_d;
        win_q[0] <= mag_q;
        for (int unsigned i = 1; i < WIN_LEN; i++) win_q[i] <= win_q[i-1];
      end
    end
  end

  // Stage 4: hysteresis comparator, evaluated on each energy strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_on_q  <= 1'b0;
      carrier_chg_q <= 1'b0;
    end else begin
      carrier_chg_q <= 1'b0;
      if (energy_en_q) begin
        if (!carrier_on_q && (energy_q >= TH_HI)) begin
          carrier_on_q  <= 1'b1;
          carrier_chg_q <= 1'b1;
        end else if (carrier_on_q && (energy_q < TH_LO)) begin
          carrier_on_q  <= 1'b0;
          carrier_chg_q <= 1'b1;
        end
      end
    end
  end

  assign energy_en   = energy_en_q;
  assign energy      = energy_q;
  assign carrier_on  = carrier_on_q;
  assign carrier_chg = carrier_chg_q;

endmodule

// File: tb/tb_nfc_subcarrier_detect.sv
// Testbench for nfc_subcarrier_detect.
// Randomised stimulus is compared against a sample-level reference model.
// Build with SUBCARRIER_DC_REMOVE_EN defined or undefined, matching the RTL build.
module tb_nfc_subcarrier_detect;

  localparam int unsigned DC_SHIFT = 6;
  localparam int unsigned WIN_LEN  = 3;
  localparam int          TH_HI    = 1200;
  localparam int          TH_LO    = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_data_en = 1'b0;
  logic [11:0] adc_data = '0;
  logic        energy_en;
  logic [15:0] energy;
  logic        carrier_on;
  logic        carrier_chg;

  nfc_subcarrier_detect #(
    .DC_SHIFT(DC_SHIFT),
    .WIN_LEN (WIN_LEN),
    .TH_HI   (16'(TH_HI)),
    .TH_LO   (16'(TH_LO))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_data_en(adc_data_en),
    .adc_data   (adc_data),
    .energy_en  (energy_en),
    .energy     (energy),
    .carrier_on (carrier_on),
    .carrier_chg(carrier_chg)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // Reference model state: samples are processed at their strobe time, and the
  // resulting outputs are scheduled on the cycle the spec says they become visible.
  typedef struct { int due; int e; } ev_t;
  typedef struct { int due; bit on; bit chg; } cev_t;
  ev_t  eq[$];
  cev_t cq[$];
  int   m_acc;
  int   m_win[$];
  bit   m_on;
  bit   exp_en, exp_on, exp_chg;
  int   exp_energy;

  task automatic model_reset();
    eq.delete(); cq.delete(); m_win.delete();
    m_acc = 2048 << DC_SHIFT;
    m_on = 1'b0;
    exp_en = 1'b0; exp_on = 1'b0; exp_chg = 1'b0; exp_energy = 0;
  endtask

  task automatic model_sample(input int data);
    int ac, mag, e;
    bit chg;
`ifdef SUBCARRIER_DC_REMOVE_EN
    ac = data - (m_acc >> DC_SHIFT);
    m_acc = m_acc + ac;
`else
    ac = data - 2048;
`endif
    mag = (ac < 0) ? -ac : ac;
    m_win.push_front(mag);
    if (m_win.size() > WIN_LEN) void'(m_win.pop_back());
    e = 0;
    foreach (m_win[k]) e += m_win[k];
    eq.push_back('{cyc + 2, e});
    chg = 1'b0;
    if (!m_on && e >= TH_HI) begin m_on = 1'b1; chg = 1'b1; end
    else if (m_on && e < TH_LO) begin m_on = 1'b0; chg = 1'b1; end
    cq.push_back('{cyc + 3, m_on, chg});
  endtask

  // Drive one clock cycle of input and advance the model's expected outputs
  task automatic drive_cycle(input bit en, input int data);
    adc_data_en = en;
    adc_data    = data[11:0];
    @(posedge clk); #1;
    cyc++;
    if (en) model_sample(data);
    exp_en = 1'b0; exp_chg = 1'b0;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      exp_en = 1'b1; exp_energy = eq[0].e; void'(eq.pop_front());
    end
    if (cq.size() > 0 && cq[0].due == cyc) begin
      exp_on = cq[0].on; exp_chg = cq[0].chg; void'(cq.pop_front());
    end
    adc_data_en = 1'b0;
  endtask

  task automatic apply_reset(input bit with_sample);
    rst = 1'b1;
    adc_data_en = with_sample;
    adc_data = 12'($urandom_range(0, 4095));
    @(posedge clk); #1;
    cyc++;
    model_reset();
    rst = 1'b0;
    adc_data_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (energy_en !== 1'b0) $display("FAIL reset energy_en got %0b want 0", energy_en); else n_pass++;
    n_total++; if (energy !== 16'd0) $display("FAIL reset energy got %0d want 0", energy); else n_pass++;
    n_total++; if (carrier_on !== 1'b0) $display("FAIL reset carrier_on got %0b want 0", carrier_on); else n_pass++;
    n_total++; if (carrier_chg !== 1'b0) $display("FAIL reset carrier_chg got %0b want 0", carrier_chg); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_dc_zero();
    int sent = 0;
    int chg_seen = 0;
    while (sent < 50 || eq.size() > 0 || cq.size() > 0) begin
      bit en;
      en = (sent < 50) && ($urandom_range(0, 3) != 0);
      drive_cycle(en, 2048);
      if (en) sent++;
      if (carrier_chg === 1'b1) chg_seen++;
      n_total++; if (energy_en !== exp_en) $display("FAIL dc_zero energy_en got %0b want %0b", energy_en, exp_en); else n_pass++;
      n_total++; if (energy !== 16'(exp_energy)) $display("FAIL dc_zero energy got %0d want %0d", energy, exp_energy); else n_pass++;
      n_total++; if (carrier_on !== exp_on) $display("FAIL dc_zero carrier_on got %0b want %0b", carrier_on, exp_on); else n_pass++;
      n_total++; if (carrier_chg !== exp_chg) $display("FAIL dc_zero carrier_chg got %0b want %0b", carrier_chg, exp_chg); else n_pass++;
    end
    n_total++; if (energy !== 16'd0) $display("FAIL dc_zero final energy got %0d want 0", energy); else n_pass++;
    n_total++; if (chg_seen != 0) $display("FAIL dc_zero chg pulses got %0d want 0", chg_seen); else n_pass++;
  endtask

  task automatic test_tones();
    int pat_a [3] = '{3048, 1548, 1548};
    int pat_b [3] = '{2498, 1823, 1823};
    int chg_seen = 0;
    for (int seg = 0; seg < 3; seg++) begin
      int n = 0;
      while (n < 45 || eq.size() > 0 || cq.size() > 0) begin
        bit en;
        int d;
        en = (n < 45) && ($urandom_range(0, 2) != 0);
        d  = (seg == 0) ? pat_a[n % 3] : (seg == 1) ? pat_b[n % 3] : 2048;
        drive_cycle(en, d);
        if (en) n++;
        if (carrier_chg === 1'b1) chg_seen++;
        n_total++; if (energy_en !== exp_en) $display("FAIL tones energy_en got %0b want %0b", energy_en, exp_en); else n_pass++;
        n_total++; if (energy !== 16'(exp_energy)) $display("FAIL tones energy got %0d want %0d", energy, exp_energy); else n_pass++;
        n_total++; if (carrier_on !== exp_on) $display("FAIL tones carrier_on got %0b want %0b", carrier_on, exp_on); else n_pass++;
        n_total++; if (carrier_chg !== exp_chg) $display("FAIL tones carrier_chg got %0b want %0b", carrier_chg, exp_chg); else n_pass++;
      end
`ifndef SUBCARRIER_DC_REMOVE_EN
      if (seg == 0) begin
        n_total++; if (energy !== 16'd2000) $display("FAIL tones strong energy got %0d want 2000", energy); else n_pass++;
      end
      if (seg == 1) begin
        n_total++; if (energy !== 16'd900) $display("FAIL tones weak energy got %0d want 900", energy); else n_pass++;
      end
`endif
      n_total++; if (carrier_on !== (seg != 2)) $display("FAIL tones seg%0d carrier_on got %0b want %0b", seg, carrier_on, seg != 2); else n_pass++;
    end
    n_total++; if (chg_seen != 2) $display("FAIL tones chg pulses got %0d want 2", chg_seen); else n_pass++;
  endtask

  task automatic test_const3000();
    int strobes = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 30; i++) begin
      drive_cycle(i < 24, 3000);
      n_total++; if (energy_en !== exp_en) $display("FAIL c3000 energy_en got %0b want %0b", energy_en, exp_en); else n_pass++;
      n_total++; if (energy !== 16'(exp_energy)) $display("FAIL c3000 energy got %0d want %0d", energy, exp_energy); else n_pass++;
      n_total++; if (carrier_on !== exp_on) $display("FAIL c3000 carrier_on got %0b want %0b", carrier_on, exp_on); else n_pass++;
      n_total++; if (carrier_chg !== exp_chg) $display("FAIL c3000 carrier_chg got %0b want %0b", carrier_chg, exp_chg); else n_pass++;
`ifndef SUBCARRIER_DC_REMOVE_EN
      if (energy_en === 1'b1) begin
        strobes++;
        n_total++;
        if (energy !== 16'(952 * ((strobes < 3) ? strobes : 3)))
          $display("FAIL c3000 fill%0d energy got %0d want %0d", strobes, energy, 952 * ((strobes < 3) ? strobes : 3));
        else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(i < 10, $urandom_range(0, 4095));
      if (energy_en === 1'b1) pulses++;
      n_total++; if (energy_en !== exp_en) $display("FAIL b2b energy_en got %0b want %0b", energy_en, exp_en); else n_pass++;
      n_total++; if (energy !== 16'(exp_energy)) $display("FAIL b2b energy got %0d want %0d", energy, exp_energy); else n_pass++;
      n_total++; if (carrier_on !== exp_on) $display("FAIL b2b carrier_on got %0b want %0b", carrier_on, exp_on); else n_pass++;
      n_total++; if (carrier_chg !== exp_chg) $display("FAIL b2b carrier_chg got %0b want %0b", carrier_chg, exp_chg); else n_pass++;
    end
    n_total++; if (pulses != 10) $display("FAIL b2b pulse count got %0d want 10", pulses); else n_pass++;
  endtask

  task automatic test_random();
    int amp = 0;
    int ph = 0;
    for (int i = 0; i < 400; i++) begin
      bit en;
      int d;
      if (i % 40 == 0) amp = $urandom_range(0, 800);
      en = ($urandom_range(0, 1) == 1);
      d = (i >= 320) ? $urandom_range(0, 4095) : ((ph == 0) ? 2048 + 2 * amp : 2048 - amp);
      if (en) ph = (ph + 1) % 3;
      drive_cycle(en, d);
      n_total++; if (energy_en !== exp_en) $display("FAIL random energy_en got %0b want %0b", energy_en, exp_en); else n_pass++;
      n_total++; if (energy !== 16'(exp_energy)) $display("FAIL random energy got %0d want %0d", energy, exp_energy); else n_pass++;
      n_total++; if (carrier_on !== exp_on) $display("FAIL random carrier_on got %0b want %0b", carrier_on, exp_on); else n_pass++;
      n_total++; if (carrier_chg !== exp_chg) $display("FAIL random carrier_chg got %0b want %0b", carrier_chg, exp_chg); else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    // Push the carrier on first so the reset visibly clears it
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, (i % 3 == 0) ? 3500 : 1300);
    drive_cycle(1'b1, 3500);
    drive_cycle(1'b1, 1300);
    apply_reset(1'b1);
    n_total++; if (energy_en !== 1'b0) $display("FAIL midrst energy_en got %0b want 0", energy_en); else n_pass++;
    n_total++; if (energy !== 16'd0) $display("FAIL midrst energy got %0d want 0", energy); else n_pass++;
    n_total++; if (carrier_on !== 1'b0) $display("FAIL midrst carrier_on got %0b want 0", carrier_on); else n_pass++;
    n_total++; if (carrier_chg !== 1'b0) $display("FAIL midrst carrier_chg got %0b want 0", carrier_chg); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      drive_cycle((i >= 5) && (i < 12), 2048 + 150 * i);
      n_total++; if (energy_en !== exp_en) $display("FAIL midrst energy_en got %0b want %0b", energy_en, exp_en); else n_pass++;
      n_total++; if (energy !== 16'(exp_energy)) $display("FAIL midrst energy got %0d want %0d", energy, exp_energy); else n_pass++;
      n_total++; if (carrier_on !== exp_on) $display("FAIL midrst carrier_on got %0b want %0b", carrier_on, exp_on); else n_pass++;
      n_total++; if (carrier_chg !== exp_chg) $display("FAIL midrst carrier_chg got %0b want %0b", carrier_chg, exp_chg); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_dc_zero();
    test_tones();
    test_const3000();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
